// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_e;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_1000;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Redirect, instruction-memory and decode handshakes of the fetch sequencer.
interface fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] redirect_imm;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             inst_valid;
    logic [31:0]      inst_data;
    logic [WIDTH-1:0] inst_pc;
    logic             inst_ready;

    modport master (
        input  redirect_valid, redirect_pc, redirect_imm,
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc, redirect_imm,
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_pc_next.sv
// Next-PC select (sequential advance vs redirect target) and the pc_q register.
module fetch_pc_next
    import fetch_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic [WIDTH-1:0] redirect_imm_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] target_o,
    output logic [WIDTH-1:0] pc_o
);
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Both sums wrap modulo 2^WIDTH; the immediate's sign falls out of two's complement.
    assign target_o = redirect_pc_i + redirect_imm_i;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_o;
        end else if (advance_i) begin
            pc_d = pc_q + WIDTH'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the req/ack instruction memory and
// presents instructions to decode, discarding fetches made stale by redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master ctrl_io
);
    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] req_addr_q, req_addr_d;
    logic [31:0]      inst_data_q, inst_data_d;
    logic [WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] target;
    logic             advance;

    // In REQ pc_q always equals req_addr_q, so advancing pc_q yields req_addr_q + 4.
    assign advance = (state_q == ST_REQ) && ctrl_io.imem_ack && !ctrl_io.redirect_valid;

    fetch_pc_next #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_next (
        .clk            (clk),
        .rst            (rst),
        .redirect_i     (ctrl_io.redirect_valid),
        .redirect_pc_i  (ctrl_io.redirect_pc),
        .redirect_imm_i (ctrl_io.redirect_imm),
        .advance_i      (advance),
        .target_o       (target),
        .pc_o           (pc_q)
    );

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                state_d    = ST_REQ;
                req_addr_d = ctrl_io.redirect_valid ? target : pc_q;
            end
            ST_REQ: begin
                if (ctrl_io.imem_ack) begin
                    if (ctrl_io.redirect_valid) begin
                        req_addr_d = target;
                    end else begin
                        inst_data_d = ctrl_io.imem_rdata;
                        inst_pc_d   = req_addr_q;
                        state_d     = ST_VALID;
                    end
                end else if (ctrl_io.redirect_valid) begin
                    // The request cannot be withdrawn; wait for its ack and drop it.
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ctrl_io.imem_ack) begin
                    req_addr_d = ctrl_io.redirect_valid ? target : pc_q;
                    state_d    = ST_REQ;
                end
            end
            ST_VALID: begin
                if (ctrl_io.redirect_valid) begin
                    req_addr_d = target;
                    state_d    = ST_REQ;
                end else if (ctrl_io.inst_ready) begin
                    req_addr_d = pc_q;
                    state_d    = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_addr_q  <= '0;
            inst_data_q <= '0;
            inst_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            inst_data_q <= inst_data_d;
            inst_pc_q   <= inst_pc_d;
        end
    end

    assign ctrl_io.imem_req   = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign ctrl_io.imem_addr  = req_addr_q;
    assign ctrl_io.inst_valid = (state_q == ST_VALID);
    assign ctrl_io.inst_data  = inst_data_q;
    assign ctrl_io.inst_pc    = inst_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus pushes expected instructions into a
// scoreboard, a monitor pops one per new presentation on the decode side.
module tb_fetch_ctrl;
    logic clk;
    logic rst;

    fetch_ctrl_if #(.WIDTH(32)) bus ();

    fetch_ctrl #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_1000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_io (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_data_q[$];
    logic        prev_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a request at addr, hold ack low for waits cycles, then ack with data.
    task automatic serve(input logic [31:0] addr, input int waits, input logic [31:0] data);
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", 32'(bus.imem_req), 32'd1);
            chk("wait_addr", bus.imem_addr, addr);
            chk("wait_no_valid", 32'(bus.inst_valid), 32'd0);
            tick();
        end
        chk("ack_req", 32'(bus.imem_req), 32'd1);
        chk("ack_addr", bus.imem_addr, addr);
        chk("ack_no_valid", 32'(bus.inst_valid), 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        exp_pc_q.push_back(addr);
        exp_data_q.push_back(data);
        tick();
        bus.imem_ack = 1'b0;
        chk("present_valid", 32'(bus.inst_valid), 32'd1);
        chk("present_no_req", 32'(bus.imem_req), 32'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_data", bus.inst_data, 32'd0);
        chk("rst_pc", bus.inst_pc, 32'd0);
    endtask

    // Scoreboard monitor: each fresh presentation must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.inst_valid && !prev_valid) begin
            if (exp_pc_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got pc 0x%08h data 0x%08h, none expected", bus.inst_pc, bus.inst_data);
            end else begin
                chk("sb_pc", bus.inst_pc, exp_pc_q.pop_front());
                chk("sb_data", bus.inst_data, exp_data_q.pop_front());
            end
        end
        prev_valid = bus.inst_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.redirect_imm   = '0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = '0;
        bus.inst_ready     = 1'b0;
        repeat (3) tick();
        chk_reset_outputs();
        rst = 1'b0;
        tick();

        // Plan 1: zero-wait fetch at the reset vector, immediate accept.
        bus.inst_ready = 1'b1;
        serve(32'h1000, 0, 32'h0050_0093);
        chk("t1_inst_pc", bus.inst_pc, 32'h1000);
        tick();
        bus.inst_ready = 1'b0;
        chk("t1_next_req", 32'(bus.imem_req), 32'd1);
        chk("t1_next_addr", bus.imem_addr, 32'h1004);

        // Plan 2 and 3: three wait states, then decode stalls four cycles.
        serve(32'h1004, 3, 32'h00A0_0113);
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_valid", 32'(bus.inst_valid), 32'd1);
            chk("t3_hold_data", bus.inst_data, 32'h00A0_0113);
            chk("t3_hold_pc", bus.inst_pc, 32'h1004);
            chk("t3_hold_no_req", 32'(bus.imem_req), 32'd0);
            tick();
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("t3_req_addr", bus.imem_addr, 32'h1008);

        // Plan 4: redirect while the 0x1008 request is outstanding.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1004;
        bus.redirect_imm   = 32'h20;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t4_drain_req", 32'(bus.imem_req), 32'd1);
            chk("t4_drain_addr", bus.imem_addr, 32'h1008);
            chk("t4_drain_no_valid", 32'(bus.inst_valid), 32'd0);
            tick();
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        chk("t4_discard_valid", 32'(bus.inst_valid), 32'd0);
        serve(32'h1024, 0, 32'h0010_8093);

        // Plan 5: redirect and ready together in VALID; redirect wins.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1010;
        bus.redirect_imm   = 32'hFFFF_FFF0;
        bus.inst_ready     = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        chk("t5_valid_dropped", 32'(bus.inst_valid), 32'd0);
        serve(32'h1000, 1, 32'h1111_1111);

        // Plan 6: reset while draining, then a late ack.
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h2000;
        bus.redirect_imm   = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t6_drain_addr", bus.imem_addr, 32'h1004);
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        chk_reset_outputs();
        tick();
        bus.imem_ack = 1'b0;
        chk("t6_late_ack_no_valid", 32'(bus.inst_valid), 32'd0);

        // Wrap: ack and redirect together retarget to 0xFFFFFFFC, then 0x0.
        chk("t6_first_addr", bus.imem_addr, 32'h1000);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF0;
        bus.redirect_imm   = 32'hC;
        bus.imem_ack       = 1'b1;
        bus.imem_rdata     = 32'hBAD1_BAD1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.imem_ack       = 1'b0;
        serve(32'hFFFF_FFFC, 0, 32'h2222_2222);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        serve(32'h0000_0000, 2, 32'h3333_3333);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;

        // Redirect in IDLE steers the very first request after reset.
        rst = 1'b1;
        tick();
        rst                = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h4000;
        bus.redirect_imm   = 32'h0;
        chk("idle_no_req", 32'(bus.imem_req), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        serve(32'h4000, 0, 32'h4444_4444);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        chk("after_accept_addr", bus.imem_addr, 32'h4004);
        repeat (2) tick();

        chk("sb_drained", 32'(exp_pc_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the program counter and drives a variable-latency instruction memory through a req/ack handshake. It presents fetched instructions to decode with a valid/ready handshake. It applies branch/jump redirects (target = redirect_pc + redirect_imm) from execute and discards any in-flight fetch the redirect makes stale. It replaces the free-running PC register in the multi-cycle core.

Parameters:
WIDTH, 32, address/PC width in bits
RESET_VECTOR, 32'h1000, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
redirect_valid  in  1  execute requests a PC redirect this cycle
redirect_pc  in  WIDTH  PC of the redirecting instruction
redirect_imm  in  WIDTH  signed offset; target = redirect_pc + redirect_imm
imem_req  out  1  fetch request valid
imem_addr  out  WIDTH  fetch address; stable while imem_req=1 and imem_ack=0
imem_ack  in  1  memory completes the request this cycle; ignored when imem_req=0
imem_rdata  in  32  instruction word, valid when imem_ack=1
inst_valid  out  1  instruction available to decode
inst_data  out  32  instruction word
inst_pc  out  WIDTH  address of inst_data
inst_ready  in  1  decode accepts the instruction when inst_valid=1

Behaviour:
- Registers: state, pc_q (next address to fetch), req_addr_q (address of the outstanding request), inst_data_q, inst_pc_q.
- Reset (rst=1 at an edge, from any state, including with a request outstanding): state=IDLE, pc_q=RESET_VECTOR, req_addr_q=0, inst_data=0, inst_pc=0.
- Outputs on the cycle after reset: imem_req=0, inst_valid=0.
- A memory ack arriving after reset is ignored.
- Target arithmetic: redirect_pc + redirect_imm, modulo 2^WIDTH. pc_q + 4 also wraps (0xFFFFFFFC -> 0). No alignment check is performed.
- States:
  - IDLE: imem_req=0, inst_valid=0.
    - Next state is REQ with req_addr_q=pc_q.
    - A redirect in IDLE sets pc_q=target, and the first request uses the target.
  - REQ: imem_req=1, imem_addr=req_addr_q.
    - ack && !redirect: inst_data_q=imem_rdata, inst_pc_q=req_addr_q, pc_q=req_addr_q+4; go to VALID.
    - ack && redirect: drop the data; pc_q=target, req_addr_q=target; stay in REQ (new request next cycle).
    - !ack && redirect: pc_q=target; go to DRAIN. The request is not withdrawn.
    - !ack && !redirect: hold; the address does not change.
  - DRAIN: imem_req=1, imem_addr=req_addr_q (stale address), inst_valid=0.
    - Further redirects overwrite pc_q; the last one wins.
    - On ack: discard rdata; req_addr_q = pc_q (or the target, if a redirect arrives in the same cycle); go to REQ.
  - VALID: inst_valid=1, imem_req=0.
    - Redirect has priority over inst_ready: inst_valid drops next cycle, pc_q=target, req_addr_q=target; go to REQ.
    - inst_ready && !redirect: req_addr_q=pc_q; go to REQ.
    - Otherwise hold; inst_data and inst_pc are stable.
- Latency:
  - Request to inst_valid = ack wait states + 1 cycle.
  - Handshake to next imem_req = 1 cycle.
  - Peak throughput with zero-wait memory: one instruction per 2 cycles.
- Invariants:
  - imem_req never falls without an ack.
  - inst_valid never falls without inst_ready or a redirect.
  - No stale instruction is ever presented.

Decomposition:
- fetch_pkg: state enum (IDLE, REQ, DRAIN, VALID), INSTR_BYTES=4, default RESET_VECTOR.
- One sub-module, fetch_pc_next: combinational next-PC select (pc_q+4 vs redirect target) plus the pc_q register with reset to RESET_VECTOR. The FSM and output registers stay in fetch_ctrl.

Test Plan:
1. Release reset; ack in the first REQ cycle with rdata=0x00500093 -> IDLE 1 cycle; req at 0x1000; next cycle inst_valid=1, inst_pc=0x1000; inst_ready=1 -> next req at 0x1004.
2. Hold ack low 3 cycles on the 0x1004 request -> imem_addr stays 0x1004 and imem_req stays 1 throughout; inst_valid stays 0 until the cycle after ack.
3. inst_ready=0 for 4 cycles in VALID -> inst_valid, inst_data and inst_pc constant; imem_req=0; fetch of 0x1008 starts only after the ready cycle.
4. Outstanding req at 0x1008, no ack; redirect_pc=0x1004, redirect_imm=0x20 -> DRAIN keeps addr 0x1008 until ack; data discarded (inst_valid=0); next req at 0x1024.
5. In VALID, redirect_pc=0x1010, redirect_imm=0xFFFFFFF0 with inst_ready=1 in the same cycle -> redirect wins, inst_valid=0 next cycle, next req at 0x1000.
6. rst pulsed while in DRAIN; late ack arrives after reset -> next cycle imem_req=0, inst_valid=0, inst_data=0; late ack ignored; first request after reset at 0x1000. Separately, redirect to 0xFFFFFFFC -> fetch after it at 0x00000000.
